// File: rtl/ctrl_contador_t.sv
// Controller for an external bank of T flip-flops that counts modulo MOD.
// The controller registers its decisions on the rising edge; the bank updates on the falling edge.
module ctrl_contador_t #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] t_o,
  output logic [WIDTH-1:0] clr_o,
  output logic [WIDTH-1:0] prst_o,
  output logic             en_o,
  output logic             busy,
  output logic             tc,
  output logic             err,
  output logic [2:0]       dbg_state
);

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LOAD  = 3'd3,
    CLR   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] t_nx;
  logic [WIDTH-1:0] clr_nx;
  logic [WIDTH-1:0] prst_nx;
  logic             tc_nx;
  logic             err_nx;
  logic             over;
  logic [WIDTH-1:0] load_sat;

  // Ripple toggle pattern: bit i toggles when every lower bit is 1 (up) or 0 (down).
  function automatic logic [WIDTH-1:0] step_mask(input logic [WIDTH-1:0] q, input logic up);
    logic [WIDTH-1:0] m;
    logic             carry;
    m     = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      m[i]  = carry;
      carry = carry & (up ? q[i] : ~q[i]);
    end
    return m;
  endfunction

  always_comb begin
    over     = ({1'b0, load_val} >= MOD_EXT);
    load_sat = over ? TOP : load_val;
  end

  // Next state: clear > load > stop > start.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = CLR;
    end else if (load) begin
      state_nx = LOAD;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = RUN;
        RUN:     if (stop)  state_nx = PAUSE;
        PAUSE:   if (start) state_nx = RUN;
        LOAD:    state_nx = PAUSE;
        CLR:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Bank drive for the cycle being entered, computed from the settled q_fb.
  always_comb begin
    t_nx    = '0;
    clr_nx  = '0;
    prst_nx = '0;
    tc_nx   = 1'b0;
    err_nx  = 1'b0;
    case (state_nx)
      RUN: begin
        if (dir) begin
          if (q_fb == TOP) begin
            clr_nx = '1;
            tc_nx  = 1'b1;
          end else begin
            t_nx = step_mask(q_fb, 1'b1);
          end
        end else begin
          if (q_fb == '0) begin
            prst_nx = TOP;
            clr_nx  = ~TOP;
            tc_nx   = 1'b1;
          end else begin
            t_nx = step_mask(q_fb, 1'b0);
          end
        end
      end
      LOAD: begin
        prst_nx = load_sat;
        clr_nx  = ~load_sat;
        err_nx  = over;
      end
      CLR: begin
        clr_nx = '1;
      end
      default: begin
        t_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      t_o    <= '0;
      clr_o  <= '1;
      prst_o <= '0;
      en_o   <= 1'b1;
      busy   <= 1'b0;
      tc     <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      t_o    <= t_nx;
      clr_o  <= clr_nx;
      prst_o <= prst_nx;
      en_o   <= 1'b1;
      busy   <= (state_nx == RUN);
      tc     <= tc_nx;
      err    <= err_nx;
    end
  end

  assign dbg_state = state;

  // A bit must never be cleared and preset at once.
  a_no_clr_prst: assert property (@(posedge clk) disable iff (!clr_n) (clr_o & prst_o) == '0);

endmodule

// File: tb/tb_ctrl_contador_t.sv
// Bench for ctrl_contador_t driving a behavioural T flip-flop bank on the falling edge.
module tb_ctrl_contador_t;
  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         clr_n = 1'b1;
  logic         start = 1'b0, stop = 1'b0, load = 1'b0, clear = 1'b0, dir = 1'b1;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q_fb = 4'd13;
  logic [W-1:0] t_o, clr_o, prst_o;
  logic         en_o, busy, tc, err;
  logic [2:0]   dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LOAD, M_CLR} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_cnt  = 0;

  typedef struct {
    logic       s, sp, ld, cl;
    logic [3:0] lv;
    logic       d;
    int         q;
    logic       tc, busy, err;
  } vec_t;
  vec_t vecs[$];

  ctrl_contador_t #(.WIDTH(W), .MOD(MOD)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .load(load), .clear(clear),
    .load_val(load_val), .dir(dir), .q_fb(q_fb), .t_o(t_o), .clr_o(clr_o),
    .prst_o(prst_o), .en_o(en_o), .busy(busy), .tc(tc), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Bank of T flip-flops with per-bit clear/preset, acting on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (en_o) begin
        if (clr_o[i])       q_fb[i] <= 1'b0;
        else if (prst_o[i]) q_fb[i] <= 1'b1;
        else if (t_o[i])    q_fb[i] <= ~q_fb[i];
      end
    end
  end

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  // One clock of commands, checked against a counter model of controller plus bank.
  task automatic step(input logic s, input logic sp, input logic ld, input logic cl,
                      input logic [3:0] lv, input logic d);
    int   nxt;
    logic tc_e, err_e;
    start = s; stop = sp; load = ld; clear = cl; load_val = lv; dir = d;
    @(posedge clk);
    #1;
    nxt = m_cnt; tc_e = 1'b0; err_e = 1'b0;
    if (cl) begin
      m_mode = M_CLR; nxt = 0;
    end else if (ld) begin
      m_mode = M_LOAD;
      if (int'(lv) >= MOD) begin nxt = MOD - 1; err_e = 1'b1; end
      else nxt = int'(lv);
    end else begin
      case (m_mode)
        M_IDLE, M_PAUSE: if (s) m_mode = M_RUN;
        M_RUN:           if (sp) m_mode = M_PAUSE;
        M_LOAD:          m_mode = M_PAUSE;
        M_CLR:           m_mode = M_IDLE;
        default:         m_mode = M_IDLE;
      endcase
      if (m_mode == M_RUN) begin
        if (d) begin
          if (m_cnt == MOD - 1) begin nxt = 0; tc_e = 1'b1; end
          else nxt = (m_cnt + 1) % (1 << W);
        end else begin
          if (m_cnt == 0) begin nxt = MOD - 1; tc_e = 1'b1; end
          else nxt = m_cnt - 1;
        end
      end
    end
    chk("model_q", int'(q_fb), m_cnt);
    chk("model_busy", int'(busy), int'(m_mode == M_RUN));
    chk("model_tc", int'(tc), int'(tc_e));
    chk("model_err", int'(err), int'(err_e));
    chk("clr_prst_overlap", int'(clr_o & prst_o), 0);
    chk("en_o", int'(en_o), 1);
    m_cnt = nxt;
  endtask

  // Reset pulse: outputs are forced at once and the bank clears on the next falling edge.
  task automatic reset_pulse();
    clr_n = 1'b0;
    #1;
    chk("rst_clr_o", int'(clr_o), 15);
    chk("rst_t_o", int'(t_o), 0);
    chk("rst_prst_o", int'(prst_o), 0);
    chk("rst_en_o", int'(en_o), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    #1;
    chk("rst_q_fb", int'(q_fb), 0);
    @(posedge clk);
    #2;
    clr_n = 1'b1;
    m_mode = M_IDLE;
    m_cnt  = 0;
    step(0, 0, 0, 0, 0, 1);
    chk("rst_release_clr_o", int'(clr_o), 0);
  endtask

  function automatic void add(logic s, logic sp, logic ld, logic cl, logic [3:0] lv, logic d,
                              int q, logic tc_e, logic busy_e, logic err_e);
    vec_t v;
    v.s = s; v.sp = sp; v.ld = ld; v.cl = cl; v.lv = lv; v.d = d;
    v.q = q; v.tc = tc_e; v.busy = busy_e; v.err = err_e;
    vecs.push_back(v);
  endfunction

  initial begin
    // Up count 0..9 then wrap.
    add(1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 0, 0, 1, k, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 9, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    // Load 3, count down through the wrap.
    add(0, 0, 1, 0, 3, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 9, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 8, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 7, 0, 0, 0);
    // Clamped load of 12.
    add(0, 0, 1, 0, 12, 1, 7, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    // Resume up, pause at 5, hold, resume at 6.
    add(1, 0, 0, 0, 0, 1, 9, 1, 1, 0);
    for (int k = 0; k <= 4; k++) add(0, 0, 0, 0, 0, 1, k, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 5, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 5, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 6, 0, 1, 0);
    // Direction change mid-run, then stop twice.
    add(0, 0, 0, 0, 0, 0, 7, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 6, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 7, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 7, 0, 0, 0);

    #2;
    reset_pulse();

    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].sp, vecs[i].ld, vecs[i].cl, vecs[i].lv, vecs[i].d);
      chk($sformatf("vec%0d_q", i), int'(q_fb), vecs[i].q);
      chk($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].tc));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].err));
    end

    // Clamped load drives the bank with 9.
    step(0, 0, 1, 0, 12, 1);
    chk("load12_prst_o", int'(prst_o), 9);
    chk("load12_clr_o", int'(clr_o), 6);
    chk("load12_err", int'(err), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("load12_pause_q", int'(q_fb), 9);

    // clear + load + start in one RUN cycle: clear wins.
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 1, 5, 1);
    chk("race_clr_o", int'(clr_o), 15);
    chk("race_t_o", int'(t_o), 0);
    chk("race_busy", int'(busy), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("race_q", int'(q_fb), 0);
    step(0, 1, 0, 0, 0, 1);
    chk("race_idle_busy", int'(busy), 0);

    // Reset mid-run at 7.
    step(1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 7; k++) step(0, 0, 0, 0, 0, 1);
    chk("midrun_q", int'(q_fb), 7);
    reset_pulse();

    // Reset mid-load suppresses err.
    step(0, 0, 1, 0, 13, 1);
    reset_pulse();

    // Randomized commands.
    for (int n = 0; n < 400; n++) begin
      logic d;
      d = dir;
      if ($urandom_range(0, 7) == 0) d = ~d;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 23) == 0,
           4'($urandom_range(0, 15)), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
